aer_encoder: RTL



---
 rtl/aer_encoder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/aer_encoder.sv
// AER transmitter: timestamps per-channel spikes, arbitrates round-robin
// into a first-word-fall-through FIFO of {channel_id, timestamp} words.
module aer_encoder #(
    parameter int NUM_CH     = 16,
    parameter int TS_W       = 20,
    parameter int TICK_DIV   = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    spike_in,
    input  logic                 aer_ready,
    output logic [4+TS_W-1:0]    aer_data,
    output logic                 aer_valid,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 overflow,
    output logic [7:0]           drop_count
);

    localparam int ID_W = 4;
    localparam int W    = ID_W + TS_W;
    localparam int AW   = $clog2(FIFO_DEPTH);

    logic [15:0]       presc;
    logic              tick;
    logic [TS_W-1:0]   ts;

    logic [NUM_CH-1:0] pending;
    logic [TS_W-1:0]   ts_latch [NUM_CH];
    logic [ID_W-1:0]   rr_ptr;

    logic              grant;
    logic              grant_any;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   idx;
    logic [NUM_CH-1:0] drop_vec;
    logic [4:0]        n_drop;
    logic [8:0]        dc_sum;

    logic [W-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;

    assign tick = (presc == 16'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            ts    <= '0;
        end else if (tick) begin
            presc <= '0;
            ts    <= ts + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // First pending channel at or after rr_ptr, wrapping modulo 16.
    always_comb begin
        grant_any = 1'b0;
        win       = rr_ptr;
        idx       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = rr_ptr + ID_W'(k);
            if (!grant_any && pending[idx]) begin
                grant_any = 1'b1;
                win       = idx;
            end
        end
        grant = grant_any && !fifo_full;
    end

    always_comb begin
        drop_vec = '0;
        n_drop   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            drop_vec[i] = spike_in[i] && pending[i]
                          && !(grant && win == ID_W'(i));
            n_drop = n_drop + 5'(drop_vec[i]);
        end
        dc_sum = {1'b0, drop_count} + 9'(n_drop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            rr_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < NUM_CH; i++) ts_latch[i] <= '0;
        end else begin
            // A fresh spike on the channel being granted re-arms it.
            for (int i = 0; i < NUM_CH; i++) begin
                if (spike_in[i] && !drop_vec[i]) begin
                    pending[i]  <= 1'b1;
                    ts_latch[i] <= ts;
                end else if (grant && win == ID_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
            if (grant) rr_ptr <= win + 1'b1;
            if (|drop_vec) overflow <= 1'b1;
            drop_count <= (dc_sum > 9'd255) ? 8'hFF : dc_sum[7:0];
        end
    end

    assign push       = grant;
    assign pop        = aer_valid && aer_ready;
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign aer_valid  = !fifo_empty;
    assign aer_data   = fifo_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {win, ts_latch[win]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
